// File: rtl/evac_elevator_ctrl.sv
// evac_elevator_ctrl
//   Sequencing controller for the evacuation elevator. Floor calls are
//   latched into a pending mask. The car climbs straight to the highest
//   pending floor. It then descends to floor 0, stopping at every pending
//   floor on the way down. The door always opens at floor 0 to unload.
//   Travel and door dwell are timed with a single tick counter.
//   The block also drives the evacuation timer/display: the timer runs
//   during an evacuation, the animation follows the travel direction, and
//   the timer freezes once the building is clear.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   req_i          floor call buttons, level-sampled; bit i = floor i
//   floor_o        current floor index
//   pending_o      latched outstanding calls
//   door_open_o    high while the door is open
//   timer_stop_o   high when idle with nothing pending
//   timer_turn_o   high while the car is moving
//   timer_dir_o    travel direction, 1 = up, 0 = down
//   timer_clear_o  one-cycle pulse when an evacuation starts
module evac_elevator_ctrl #(
    parameter int NUM_FLOORS      = 4,
    parameter int TICKS_PER_FLOOR = 100000000,
    parameter int DOOR_TICKS      = 200000000,
    localparam int FW = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req_i,
    output logic [FW-1:0]         floor_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  door_open_o,
    output logic                  timer_stop_o,
    output logic                  timer_turn_o,
    output logic                  timer_dir_o,
    output logic                  timer_clear_o
);

    localparam int MAXT = (TICKS_PER_FLOOR > DOOR_TICKS) ? TICKS_PER_FLOOR : DOOR_TICKS;
    localparam int CW   = (MAXT > 2) ? $clog2(MAXT) : 1;
    localparam logic [CW-1:0] MOVE_LAST = CW'(TICKS_PER_FLOOR - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [FW-1:0]         top;
    logic [NUM_FLOORS-1:0] above_mask;
    logic                  has_above;
    logic                  terminal;
    logic [FW-1:0]         floor_up, floor_dn;

    // Highest pending floor, and whether any call lies above the car.
    always_comb begin
        top        = '0;
        above_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i]) top = FW'(i);
            if (i > int'(floor_q)) above_mask[i] = 1'b1;
        end
    end

    assign has_above = |(pending_q & above_mask);
    assign floor_up  = floor_q + 1'b1;
    assign floor_dn  = floor_q - 1'b1;

    always_comb begin
        terminal = 1'b0;
        case (state_q)
            MOVE_UP, MOVE_DOWN: terminal = (cnt_q == MOVE_LAST);
            DOOR:               terminal = (cnt_q == DOOR_LAST);
            default:            terminal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        case (state_q)
            IDLE: begin
                if (has_above)            state_d = MOVE_UP;
                else if (floor_q != '0)   state_d = MOVE_DOWN;
                else if (pending_q[0])    state_d = DOOR;
            end
            MOVE_UP: begin
                if (terminal) begin
                    floor_d = floor_up;
                    // Top-floor guard keeps the car in range even if top is stale.
                    if (floor_up == top || floor_up == TOP_FLOOR) state_d = DOOR;
                end
            end
            MOVE_DOWN: begin
                if (terminal) begin
                    floor_d = floor_dn;
                    if (pending_q[floor_dn] || floor_dn == '0) state_d = DOOR;
                end
            end
            DOOR: begin
                if (terminal) begin
                    if (has_above)          state_d = MOVE_UP;
                    else if (floor_q != '0) state_d = MOVE_DOWN;
                    else                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts on every state change and wraps after each floor/dwell.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_d != state_q || state_q == IDLE || terminal) cnt_d = '0;
    end

    // The served floor is also cleared on the edge that enters DOOR, so it
    // never reads as pending while door_open is high. Clears beat new calls.
    always_comb begin
        pending_d = pending_q | req_i;
        if (state_q == DOOR) pending_d[floor_q] = 1'b0;
        if (state_d == DOOR) pending_d[floor_d] = 1'b0;
    end

    assign floor_o       = floor_q;
    assign pending_o     = pending_q;
    assign door_open_o   = (state_q == DOOR);
    assign timer_turn_o  = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    assign timer_dir_o   = (state_q == MOVE_UP);
    assign timer_stop_o  = (state_q == IDLE) && (pending_q == '0);
    assign timer_clear_o = (state_q == IDLE) && (state_d != IDLE) && (pending_q != '0);

endmodule
